// File: rtl/mem_arbiter.sv
// Round-robin arbiter that sequences two requesters onto a single RAM port.
// Define MEM_ARB_TIMEOUT_EN to bound read waits to TIMEOUT cycles (err reported with ack).
module mem_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_clr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_rw,
  output logic              mem_clr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_out_valid
);
  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, CLEAR} state_t;

  state_t state, state_nxt;
  logic   last_gnt;
  logic   req0_m, req1_m, any_req, sel, sel_we;
  logic   rd_ok, timed_out, done;
  logic   mem_rw_d, mem_clr_d, p0_ack_d, p1_ack_d, p0_err_d, p1_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A port is not eligible in its own ack cycle, which gives the other port a turn.
  always_comb begin
    req0_m    = p0_req & ~p0_ack;
    req1_m    = p1_req & ~p1_ack;
    any_req   = req0_m | req1_m;
    sel       = (req0_m & req1_m) ? ~last_gnt : req1_m;
    sel_we    = sel ? p1_we : p0_we;
    rd_ok     = mem_out_valid | timed_out;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel && p1_clr) state_nxt = CLEAR;
          else if (sel_we)   state_nxt = WRITE;
          else               state_nxt = READ_WAIT;
        end
      end
      WRITE, CLEAR: state_nxt = IDLE;
      READ_WAIT:    if (rd_ok) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // last_gnt doubles as the owner of the in-flight transaction.
  always_comb begin
    done      = (state != IDLE) && (state_nxt == IDLE);
    mem_rw_d  = (state_nxt == WRITE);
    mem_clr_d = (state_nxt == CLEAR);
    p0_ack_d  = done & ~last_gnt;
    p1_ack_d  = done & last_gnt;
    p0_err_d  = p0_ack_d & timed_out;
    p1_err_d  = p1_ack_d & timed_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt    <= 1'b1;
      mem_rw      <= 1'b0;
      mem_clr     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_err      <= 1'b0;
      p1_err      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      mem_rw  <= mem_rw_d;
      mem_clr <= mem_clr_d;
      p0_ack  <= p0_ack_d;
      p1_ack  <= p1_ack_d;
      p0_err  <= p0_err_d;
      p1_err  <= p1_err_d;
      if (state == IDLE && any_req) begin
        last_gnt    <= sel;
        mem_address <= sel ? p1_addr : p0_addr;
        mem_data_in <= sel ? p1_wdata : p0_wdata;
      end
      if (state == READ_WAIT && rd_ok) begin
        if (last_gnt) p1_rdata <= mem_out_valid ? mem_data_out : '0;
        else          p0_rdata <= mem_out_valid ? mem_data_out : '0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] rd_cnt;

  // Counts completed wait cycles; zero on the first READ_WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rd_cnt <= '0;
    else if (state != READ_WAIT) rd_cnt <= '0;
    else                         rd_cnt <= rd_cnt + 1'b1;
  end

  assign timed_out = (state == READ_WAIT) && !mem_out_valid &&
                     (rd_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timed_out      = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic p0_req, p0_we, p0_ack, p0_err;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic p1_req, p1_we, p1_clr, p1_ack, p1_err;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic mem_rw, mem_clr, mem_out_valid;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;

  logic              use_mem, drv_valid;
  logic [DATA_W-1:0] drv_data;
  logic [DATA_W-1:0] dev_mem [16];
  logic [DATA_W-1:0] ref_mem [16];
  logic [1:0]        ackv;
  logic [57:0]       all_outs;
  int total = 0;
  int bad = 0;
  int model_last = 1;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_clr(p1_clr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_rw(mem_rw), .mem_clr(mem_clr), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_out_valid(mem_out_valid)
  );

  always #5 clk = ~clk;

  assign mem_data_out  = use_mem ? dev_mem[mem_address] : drv_data;
  assign mem_out_valid = drv_valid;
  assign ackv          = {p1_ack, p0_ack};
  assign all_outs      = {p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
                          mem_rw, mem_clr, mem_address, mem_data_in};

  // Memory device: applies whatever the arbiter puts on the bus.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= '0;
    end else if (mem_rw) begin
      dev_mem[mem_address] <= mem_data_in;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic we, input logic clr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_clr = clr; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) p0_req = 1'b0;
    else begin p1_req = 1'b0; p1_clr = 1'b0; end
  endtask

  function automatic logic [DATA_W-1:0] rdata_of(input int port);
    return (port == 0) ? p0_rdata : p1_rdata;
  endfunction

  function automatic logic err_of(input int port);
    return (port == 0) ? p0_err : p1_err;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (all_outs !== 58'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (all_outs !== 58'd0) begin
      bad++; $display("FAIL reset_idle: got %h want 0", all_outs);
    end
    model_last = 1;
  endtask

  task automatic test_write(input int port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [1:0] want;
    want = (port == 0) ? 2'b01 : 2'b10;
    drive(port, 1'b1, 1'b0, a, d);
    step();
    total++;
    if ({mem_rw, mem_clr, mem_address, mem_data_in} !== {1'b1, 1'b0, a, d}) begin
      bad++;
      $display("FAIL write_bus p%0d: got rw=%0b clr=%0b addr=%0h data=%h want rw=1 clr=0 addr=%0h data=%h",
               port, mem_rw, mem_clr, mem_address, mem_data_in, a, d);
    end
    total++;
    if (ackv !== 2'b00) begin bad++; $display("FAIL write_early_ack p%0d: got %b want 00", port, ackv); end
    step();
    total++;
    if ({ackv, mem_rw} !== {want, 1'b0}) begin
      bad++; $display("FAIL write_ack p%0d: got ack=%b rw=%0b want ack=%b rw=0", port, ackv, mem_rw, want);
    end
    drop(port);
    step();
    total++;
    if (ackv !== 2'b00) begin bad++; $display("FAIL write_ack_pulse p%0d: got %b want 00", port, ackv); end
    model_last = port;
  endtask

  task automatic test_read(input int port, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int dly);
    logic [1:0] want;
    want = (port == 0) ? 2'b01 : 2'b10;
    drv_valid = 1'b0;
    drive(port, 1'b0, 1'b0, a, $urandom);
    step();
    total++;
    if ({mem_rw, mem_clr, mem_address} !== {1'b0, 1'b0, a}) begin
      bad++; $display("FAIL read_bus p%0d: got rw=%0b clr=%0b addr=%0h want rw=0 clr=0 addr=%0h",
                      port, mem_rw, mem_clr, mem_address, a);
    end
    for (int i = 0; i < dly; i++) begin
      total++;
      if ({ackv, mem_address} !== {2'b00, a}) begin
        bad++; $display("FAIL read_wait p%0d: got ack=%b addr=%0h want ack=00 addr=%0h", port, ackv, mem_address, a);
      end
      step();
    end
    drv_data = d; drv_valid = 1'b1;
    step();
    drv_valid = 1'b0; drv_data = $urandom;
    total++;
    if ({ackv, rdata_of(port), err_of(port)} !== {want, d, 1'b0}) begin
      bad++; $display("FAIL read_ack p%0d: got ack=%b rdata=%h err=%0b want ack=%b rdata=%h err=0",
                      port, ackv, rdata_of(port), err_of(port), want, d);
    end
    drop(port);
    step();
    total++;
    if ({ackv, rdata_of(port)} !== {2'b00, d}) begin
      bad++; $display("FAIL read_hold p%0d: got ack=%b rdata=%h want ack=00 rdata=%h", port, ackv, rdata_of(port), d);
    end
    model_last = port;
  endtask

  task automatic test_clear();
    drive(1, 1'b1, 1'b1, 4'($urandom), 16'($urandom));
    step();
    total++;
    if ({mem_clr, mem_rw, ackv} !== 4'b1000) begin
      bad++; $display("FAIL clear_bus: got clr=%0b rw=%0b ack=%b want clr=1 rw=0 ack=00", mem_clr, mem_rw, ackv);
    end
    step();
    total++;
    if ({mem_clr, mem_rw, ackv} !== 4'b0010) begin
      bad++; $display("FAIL clear_ack: got clr=%0b rw=%0b ack=%b want clr=0 rw=0 ack=10", mem_clr, mem_rw, ackv);
    end
    drop(1);
    p1_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({mem_clr, mem_rw, ackv} !== 4'b0000) begin
        bad++; $display("FAIL clear_no_req: got clr=%0b rw=%0b ack=%b want all 0", mem_clr, mem_rw, ackv);
      end
    end
    p1_clr = 1'b0;
    model_last = 1;
  endtask

  task automatic test_round_robin();
    int rem [2];
    int expect_port, acks;
    logic [DATA_W-1:0] cur;
    apply_reset();
    rem[0] = 2; rem[1] = 2;
    expect_port = 1 - model_last;
    acks = 0;
    drv_valid = 1'b1;
    drive(0, 1'b0, 1'b0, 4'($urandom), '0);
    drive(1, 1'b0, 1'b0, 4'($urandom), '0);
    for (int cyc = 1; cyc <= 30 && acks < 4; cyc++) begin
      cur = 16'($urandom);
      drv_data = cur;
      step();
      if (ackv != 2'b00) begin
        total++;
        if (ackv !== ((expect_port == 0) ? 2'b01 : 2'b10) || cyc != 2 * (acks + 1)) begin
          bad++; $display("FAIL rr_order: got ack=%b at cycle %0d want p%0d at cycle %0d", ackv, cyc, expect_port, 2 * (acks + 1));
        end
        total++;
        if (rdata_of(expect_port) !== cur) begin
          bad++; $display("FAIL rr_rdata p%0d: got %h want %h", expect_port, rdata_of(expect_port), cur);
        end
        rem[expect_port]--;
        if (rem[expect_port] == 0) drop(expect_port);
        model_last = expect_port;
        expect_port = 1 - expect_port;
        acks++;
      end
    end
    total++;
    if (acks != 4) begin bad++; $display("FAIL rr_count: got %0d acks want 4", acks); end
    drv_valid = 1'b0;
    drop(0); drop(1);
    step();
  endtask

  task automatic test_random_mix();
    logic              we_a [2];
    logic              clr_a [2];
    logic [ADDR_W-1:0] addr_a [2];
    logic [DATA_W-1:0] data_a [2];
    int q [$];
    int mask, p, op;
    bit done_rd;
    use_mem = 1'b1;
    for (int r = 0; r < 40; r++) begin
      mask = (r == 0) ? 2 : $urandom_range(3, 1);
      for (int k = 0; k < 2; k++) begin
        op = (r == 0) ? 0 : $urandom_range(7, 0);
        clr_a[k]  = (k == 1) && (op == 0);
        we_a[k]   = (op >= 4) || (op == 0 && k == 1 && $urandom_range(1, 0) == 1);
        addr_a[k] = 4'($urandom);
        data_a[k] = 16'($urandom);
      end
      q.delete();
      if (mask == 3) begin q.push_back(1 - model_last); q.push_back(model_last); end
      else q.push_back(mask - 1);
      foreach (q[j]) drive(q[j], we_a[q[j]], clr_a[q[j]], addr_a[q[j]], data_a[q[j]]);
      for (int cyc = 0; cyc < 60 && q.size() > 0; cyc++) begin
        drv_valid = ($urandom_range(3, 0) != 0);
        step();
        if (ackv != 2'b00) begin
          p = p1_ack ? 1 : 0;
          total++;
          if (ackv !== ((q[0] == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL mix_order round %0d: got ack=%b want p%0d", r, ackv, q[0]);
          end
          done_rd = !clr_a[p] && !we_a[p];
          total++;
          if (err_of(p) !== 1'b0 || (done_rd && rdata_of(p) !== ref_mem[addr_a[p]])) begin
            bad++; $display("FAIL mix_data round %0d p%0d: got rdata=%h err=%0b want rdata=%h err=0",
                            r, p, rdata_of(p), err_of(p), ref_mem[addr_a[p]]);
          end
          if (clr_a[p]) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = '0;
          end else if (we_a[p]) begin
            ref_mem[addr_a[p]] = data_a[p];
          end
          model_last = p;
          drop(p);
          if (q.size() > 0 && q[0] == p) void'(q.pop_front());
          else q.delete();
        end
      end
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL mix_timeout round %0d: got %0d pending want 0", r, q.size()); end
      drop(0); drop(1);
      drv_valid = 1'b0;
      step();
    end
    use_mem = 1'b0;
  endtask

  task automatic test_timeout();
    int n, acks;
    logic [DATA_W-1:0] d;
    drv_valid = 1'b0;
    drive(0, 1'b0, 1'b0, 4'($urandom), '0);
`ifdef MEM_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step();
      if (ackv != 2'b00) n = i;
    end
    total++;
    if (n != TIMEOUT + 1) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", n, TIMEOUT + 1); end
    total++;
    if ({ackv, p0_err, p0_rdata} !== {2'b01, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL timeout_ack: got ack=%b err=%0b rdata=%h want ack=01 err=1 rdata=0000", ackv, p0_err, p0_rdata);
    end
    drop(0);
    step();
    total++;
    if ({ackv, p0_err} !== 3'b000) begin bad++; $display("FAIL timeout_pulse: got ack=%b err=%0b want 00/0", ackv, p0_err); end
`else
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ackv != 2'b00) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL no_timeout: got %0d acks want 0", acks); end
    d = 16'($urandom);
    drv_data = d; drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    total++;
    if ({ackv, p0_err, p0_rdata} !== {2'b01, 1'b0, d}) begin
      bad++; $display("FAIL late_read: got ack=%b err=%0b rdata=%h want ack=01 err=0 rdata=%h", ackv, p0_err, p0_rdata, d);
    end
    drop(0);
    step();
`endif
    model_last = 0;
  endtask

  task automatic test_reset_mid_read();
    int acks;
    drv_valid = 1'b0;
    drive(0, 1'b0, 1'b0, 4'($urandom), '0);
    step(); step(); step();
    #3 rst_n = 1'b0;
    #2;
    total++;
    if (all_outs !== 58'd0) begin bad++; $display("FAIL mid_read_reset: got %h want 0", all_outs); end
    drop(0); drop(1);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ackv != 2'b00) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL mid_read_ghost_ack: got %0d acks want 0", acks); end
    test_write(1, 4'($urandom), 16'($urandom));
  endtask

  initial begin
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_clr = 1'b0; p1_addr = '0; p1_wdata = '0;
    use_mem = 1'b0; drv_valid = 1'b0; drv_data = '0;
    test_reset();
    test_write(0, 4'd3, 16'h1234);
    test_write(1, 4'($urandom), 16'($urandom));
    test_read(1, 4'd7, 16'hBEEF, 2);
    test_read(0, 4'($urandom), 16'hA5A5, 0);
    test_clear();
    test_round_robin();
    test_random_mix();
    test_read(0, 4'($urandom), 16'h5A5A, 1);
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
